lsu_port1_ctrl: RTL and testbench

- Load/store unit between the core's MEM pipeline stage and data port 1 of the memory module.
- Accepts one load or store per transaction and performs misalignment checks.
- Aligns addresses to 8-byte words and generates byte masks and lane-shifted write data for port 1.
- Waits for port-1 responses, then sign/zero-extends load data and returns it to writeback with a stall signal to the pipeline.

---
 rtl/lsu_port1_ctrl_pkg.sv | 36 +++
 rtl/lsu_port1_ctrl_align.sv | 51 +++++
 rtl/lsu_port1_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_port1_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_port1_ctrl_pkg.sv
// Shared definitions for the port-1 load/store unit: op encodings, FSM states,
// default widths and the size/alignment helper.
package lsu_port1_ctrl_pkg;

    localparam int LSU_ADDR_W  = 32;
    localparam int LSU_XLEN    = 64;
    localparam int LSU_TIMEOUT = 64;

    typedef enum logic [2:0] {
        OP_B  = 3'd0,
        OP_H  = 3'd1,
        OP_W  = 3'd2,
        OP_D  = 3'd3,
        OP_BU = 3'd4,
        OP_HU = 3'd5,
        OP_WU = 3'd6
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } lsu_state_e;

    // Access size lives in op[1:0]; op=7 therefore falls into the D class.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] off);
        case (op[1:0])
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_port1_ctrl_align.sv
// Combinational lane logic: byte mask and write-data shift for the request,
// byte-lane extraction and sign/zero extension for the response.
module lsu_align
    import lsu_port1_ctrl_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [2:0]        req_off,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] mask,
    output logic [XLEN-1:0]   wdata_sh,
    input  logic [2:0]        resp_off,
    input  logic [2:0]        resp_op,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   rdata_ext
);

    localparam int MASK_W = XLEN / 8;

    logic [MASK_W-1:0] base;
    logic [XLEN-1:0]   sh;

    always_comb begin
        base = '0;
        case (req_op[1:0])
            2'd0:    base = MASK_W'(8'h01);
            2'd1:    base = MASK_W'(8'h03);
            2'd2:    base = MASK_W'(8'h0F);
            default: base = '1;
        endcase
    end

    assign mask     = base << req_off;
    assign wdata_sh = wdata << {req_off, 3'b000};
    assign sh       = rdata >> {resp_off, 3'b000};

    always_comb begin
        rdata_ext = sh;
        case (resp_op)
            OP_B:    rdata_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
            OP_H:    rdata_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
            OP_W:    rdata_ext = {{(XLEN-32){sh[31]}}, sh[31:0]};
            OP_BU:   rdata_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
            OP_HU:   rdata_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
            OP_WU:   rdata_ext = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: rdata_ext = sh;
        endcase
    end

endmodule

// File: rtl/lsu_port1_ctrl.sv
// Load/store unit for memory port 1: one outstanding access, alignment checks,
// response timeout and flush draining, with a stall back to the MEM stage.
module lsu_port1_ctrl
    import lsu_port1_ctrl_pkg::*;
#(
    parameter int ADDR_W  = LSU_ADDR_W,
    parameter int XLEN    = LSU_XLEN,
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    input  logic [ADDR_W-1:0] io_in_bits_addr,
    input  logic [XLEN-1:0]   io_in_bits_wdata,
    input  logic [2:0]        io_in_bits_op,
    input  logic              io_in_bits_isload,
    input  logic              io_in_bits_isstore,
    input  logic              io_flush,
    output logic              io_stall,
    output logic              io_out_valid,
    output logic [XLEN-1:0]   io_out_bits_rdata,
    output logic              io_misaligned,
    output logic              io_timeout,
    output logic              io_mem_req_valid,
    output logic [ADDR_W-1:0] io_mem_req_bits_addr,
    output logic [XLEN/8-1:0] io_mem_req_bits_mask,
    output logic [2:0]        io_mem_req_bits_op,
    output logic [XLEN-1:0]   io_mem_req_bits_wdata,
    output logic              io_mem_req_bits_memen,
    output logic              io_mem_req_bits_wen,
    input  logic              io_mem_resp_valid,
    input  logic [XLEN-1:0]   io_mem_resp_bits_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    lsu_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              tmo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        off_q;
    logic [2:0]        op_q;
    logic [XLEN/8-1:0] mask_q;
    logic [XLEN-1:0]   wdata_q;
    logic              wen_q;
    logic              memen_q;
    logic [XLEN-1:0]   rdata_q;

    logic              access;
    logic              mis;
    logic              issue;
    logic              capture;
    logic              tmo_hit;
    logic              mis_pulse;
    logic              stall;
    logic [XLEN/8-1:0] mask_in;
    logic [XLEN-1:0]   wdata_in;
    logic [XLEN-1:0]   rdata_ext;

    assign access = io_in_valid & (io_in_bits_isload | io_in_bits_isstore);
    assign mis    = is_misaligned(io_in_bits_op, io_in_bits_addr[2:0]);

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_off   (io_in_bits_addr[2:0]),
        .req_op    (io_in_bits_op),
        .wdata     (io_in_bits_wdata),
        .mask      (mask_in),
        .wdata_sh  (wdata_in),
        .resp_off  (off_q),
        .resp_op   (op_q),
        .rdata     (io_mem_resp_bits_rdata),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        mis_pulse = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access && !io_flush) begin
                    if (mis) begin
                        mis_pulse = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        stall     = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                // A response arriving with the flush is simply dropped; nothing left to drain.
                if (io_flush) begin
                    state_nxt = io_mem_resp_valid ? IDLE : DRAIN;
                end else if (io_mem_resp_valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    stall     = 1'b0;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            DRAIN: begin
                stall = io_in_valid;
                if (io_mem_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tmo_q   <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            op_q    <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            memen_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + CNT_W'(1) : '0;
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
            if (issue) begin
                addr_q  <= {io_in_bits_addr[ADDR_W-1:3], 3'b000};
                off_q   <= io_in_bits_addr[2:0];
                op_q    <= io_in_bits_op;
                mask_q  <= mask_in;
                wdata_q <= wdata_in;
                wen_q   <= io_in_bits_isstore;
                memen_q <= 1'b1;
            end
        end
    end

    // Load result is only visible while in DONE, so it needs no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            rdata_q <= wen_q ? '0 : rdata_ext;
        end
    end

    assign io_stall              = stall;
    assign io_misaligned         = mis_pulse;
    assign io_timeout            = tmo_q | tmo_hit;
    assign io_out_valid          = (state == DONE);
    assign io_out_bits_rdata     = (state == DONE) ? rdata_q : '0;
    assign io_mem_req_valid      = issue;
    assign io_mem_req_bits_addr  = issue ? {io_in_bits_addr[ADDR_W-1:3], 3'b000} : addr_q;
    assign io_mem_req_bits_mask  = issue ? mask_in : mask_q;
    assign io_mem_req_bits_op    = issue ? io_in_bits_op : op_q;
    assign io_mem_req_bits_wdata = issue ? wdata_in : wdata_q;
    assign io_mem_req_bits_memen = issue | memen_q;
    assign io_mem_req_bits_wen   = issue ? io_in_bits_isstore : wen_q;

endmodule

// File: tb/tb_lsu_port1_ctrl.sv
// Directed bench for lsu_port1_ctrl: vector table of single accesses plus
// hand-written flush/drain, stray-response and timeout sequences.
module tb_lsu_port1_ctrl;

    localparam int ADDR_W  = 32;
    localparam int XLEN    = 64;
    localparam int TIMEOUT = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [XLEN-1:0]   in_wdata = '0;
    logic [2:0]        in_op = '0;
    logic              in_isload = 1'b0;
    logic              in_isstore = 1'b0;
    logic              flush = 1'b0;
    logic              stall;
    logic              out_valid;
    logic [XLEN-1:0]   out_rdata;
    logic              misaligned;
    logic              timeout;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_mask;
    logic [2:0]        req_op;
    logic [XLEN-1:0]   req_wdata;
    logic              req_memen;
    logic              req_wen;
    logic              resp_valid = 1'b0;
    logic [XLEN-1:0]   resp_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lsu_port1_ctrl #(.ADDR_W(ADDR_W), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_in_valid            (in_valid),
        .io_in_bits_addr        (in_addr),
        .io_in_bits_wdata       (in_wdata),
        .io_in_bits_op          (in_op),
        .io_in_bits_isload      (in_isload),
        .io_in_bits_isstore     (in_isstore),
        .io_flush               (flush),
        .io_stall               (stall),
        .io_out_valid           (out_valid),
        .io_out_bits_rdata      (out_rdata),
        .io_misaligned          (misaligned),
        .io_timeout             (timeout),
        .io_mem_req_valid       (req_valid),
        .io_mem_req_bits_addr   (req_addr),
        .io_mem_req_bits_mask   (req_mask),
        .io_mem_req_bits_op     (req_op),
        .io_mem_req_bits_wdata  (req_wdata),
        .io_mem_req_bits_memen  (req_memen),
        .io_mem_req_bits_wen    (req_wen),
        .io_mem_resp_valid      (resp_valid),
        .io_mem_resp_bits_rdata (resp_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [2:0]  op;
        logic        ld;
        logic        st;
        logic [63:0] resp;
        logic        mis;
        logic [31:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [31:0] addr, input logic [63:0] wdata, input logic [2:0] op,
                                input logic ld, input logic st, input logic [63:0] resp, input logic mis,
                                input logic [31:0] e_addr, input logic [7:0] e_mask,
                                input logic [63:0] e_wdata, input logic [63:0] e_rdata);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.op = op; v.ld = ld; v.st = st; v.resp = resp;
        v.mis = mis; v.e_addr = e_addr; v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [63:0] wdata, input logic [2:0] op,
                         input logic ld, input logic st);
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_op = op;
        in_isload = ld; in_isstore = st;
    endtask

    task automatic release_in();
        in_valid = 1'b0; in_isload = 1'b0; in_isstore = 1'b0;
        in_addr = '0; in_wdata = '0; in_op = '0;
    endtask

    initial begin
        vecs[0]  = mk(32'h8000_0010, 64'h1122334455667788, 3'd3, 1'b0, 1'b1, 64'h0, 1'b0,
                      32'h8000_0010, 8'hFF, 64'h1122334455667788, 64'h0);
        vecs[1]  = mk(32'h8000_0005, 64'hAB, 3'd0, 1'b0, 1'b1, 64'h0, 1'b0,
                      32'h8000_0000, 8'h20, 64'h0000AB0000000000, 64'h0);
        vecs[2]  = mk(32'h8000_0006, 64'h0, 3'd1, 1'b1, 1'b0, 64'h8001000000000000, 1'b0,
                      32'h8000_0000, 8'hC0, 64'h0, 64'hFFFFFFFFFFFF8001);
        vecs[3]  = mk(32'h8000_0006, 64'h0, 3'd5, 1'b1, 1'b0, 64'h8001000000000000, 1'b0,
                      32'h8000_0000, 8'hC0, 64'h0, 64'h0000000000008001);
        vecs[4]  = mk(32'h8000_0002, 64'h0, 3'd2, 1'b1, 1'b0, 64'h0, 1'b1,
                      32'h0, 8'h0, 64'h0, 64'h0);
        vecs[5]  = mk(32'h8000_0008, 64'h0, 3'd3, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b0,
                      32'h8000_0008, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
        vecs[6]  = mk(32'h8000_0003, 64'h0, 3'd0, 1'b1, 1'b0, 64'h0000000080000000, 1'b0,
                      32'h8000_0000, 8'h08, 64'h0, 64'hFFFFFFFFFFFFFF80);
        vecs[7]  = mk(32'h8000_0004, 64'h0, 3'd6, 1'b1, 1'b0, 64'hFEDCBA9876543210, 1'b0,
                      32'h8000_0000, 8'hF0, 64'h0, 64'h00000000FEDCBA98);
        vecs[8]  = mk(32'h8000_0004, 64'h0, 3'd2, 1'b1, 1'b0, 64'hFEDCBA9876543210, 1'b0,
                      32'h8000_0000, 8'hF0, 64'h0, 64'hFFFFFFFFFEDCBA98);
        vecs[9]  = mk(32'h8000_0001, 64'h1234, 3'd1, 1'b0, 1'b1, 64'h0, 1'b1,
                      32'h0, 8'h0, 64'h0, 64'h0);
        vecs[10] = mk(32'h8000_0000, 64'h0, 3'd7, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b0,
                      32'h8000_0000, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
        vecs[11] = mk(32'h8000_000C, 64'hDEADBEEF, 3'd2, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0,
                      32'h8000_0008, 8'hF0, 64'hDEADBEEF00000000, 64'h0);
        vecs[12] = mk(32'h8000_0007, 64'h0, 3'd4, 1'b1, 1'b0, 64'h8000000000000000, 1'b0,
                      32'h8000_0000, 8'h80, 64'h0, 64'h0000000000000080);

        // reset
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_stall", stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rdata", out_rdata, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_mask", req_mask, 0);
        chk("rst_req_wdata", req_wdata, 0);
        chk("rst_req_memen", req_memen, 0);
        chk("rst_req_wen", req_wen, 0);

        foreach (vecs[i]) begin
            tick();
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].op, vecs[i].ld, vecs[i].st);
            #1;
            if (vecs[i].mis) begin
                chk($sformatf("v%0d_mis", i), misaligned, 1);
                chk($sformatf("v%0d_mis_reqv", i), req_valid, 0);
                chk($sformatf("v%0d_mis_stall", i), stall, 0);
                tick();
                release_in();
                #1;
                chk($sformatf("v%0d_mis_pulse", i), misaligned, 0);
                chk($sformatf("v%0d_mis_reqv2", i), req_valid, 0);
            end else begin
                chk($sformatf("v%0d_reqv", i), req_valid, 1);
                chk($sformatf("v%0d_stall0", i), stall, 1);
                chk($sformatf("v%0d_mis0", i), misaligned, 0);
                chk($sformatf("v%0d_addr", i), req_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_mask", i), req_mask, vecs[i].e_mask);
                chk($sformatf("v%0d_op", i), req_op, vecs[i].op);
                chk($sformatf("v%0d_memen", i), req_memen, 1);
                chk($sformatf("v%0d_wen", i), req_wen, vecs[i].st);
                if (vecs[i].st) chk($sformatf("v%0d_wdata", i), req_wdata, vecs[i].e_wdata);
                tick();
                release_in();
                resp_valid = 1'b1;
                resp_rdata = vecs[i].resp;
                #1;
                chk($sformatf("v%0d_wait_reqv", i), req_valid, 0);
                chk($sformatf("v%0d_wait_stall", i), stall, 1);
                chk($sformatf("v%0d_wait_addr", i), req_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_wait_outv", i), out_valid, 0);
                tick();
                resp_valid = 1'b0;
                resp_rdata = '0;
                #1;
                chk($sformatf("v%0d_done_outv", i), out_valid, 1);
                chk($sformatf("v%0d_done_stall", i), stall, 0);
                chk($sformatf("v%0d_rdata", i), out_rdata, vecs[i].e_rdata);
                tick();
                #1;
                chk($sformatf("v%0d_after_outv", i), out_valid, 0);
            end
        end

        // stray response while idle is ignored
        tick();
        resp_valid = 1'b1;
        resp_rdata = 64'h55;
        tick();
        resp_valid = 1'b0;
        #1;
        chk("stray_outv", out_valid, 0);
        chk("stray_stall", stall, 0);

        // flush in DONE keeps out_valid
        tick();
        drive(32'h8000_0020, 64'h0, 3'd3, 1'b1, 1'b0);
        tick();
        release_in();
        resp_valid = 1'b1;
        resp_rdata = 64'h77;
        tick();
        resp_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("done_flush_outv", out_valid, 1);
        chk("done_flush_rdata", out_rdata, 64'h77);
        tick();
        flush = 1'b0;

        // flush in WAIT, then drain with a held-off LB
        tick();
        drive(32'h8000_0000, 64'h0, 3'd3, 1'b1, 1'b0);
        #1;
        chk("fl_issue", req_valid, 1);
        tick();
        release_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fl_drain_stall", stall, 0);
        chk("fl_drain_outv", out_valid, 0);
        tick();
        drive(32'h8000_0001, 64'h0, 3'd0, 1'b1, 1'b0);
        #1;
        chk("fl_hold_stall", stall, 1);
        chk("fl_hold_reqv", req_valid, 0);
        tick();
        resp_valid = 1'b1;
        resp_rdata = 64'h1234;
        #1;
        chk("fl_resp_stall", stall, 1);
        chk("fl_resp_reqv", req_valid, 0);
        chk("fl_resp_outv", out_valid, 0);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("fl_lb_reqv", req_valid, 1);
        chk("fl_lb_mask", req_mask, 8'h02);
        chk("fl_lb_outv", out_valid, 0);
        tick();
        release_in();
        resp_valid = 1'b1;
        resp_rdata = 64'h000000000000FF00;
        tick();
        resp_valid = 1'b0;
        #1;
        chk("fl_lb_done", out_valid, 1);
        chk("fl_lb_rdata", out_rdata, 64'hFFFFFFFFFFFFFFFF);

        // timeout: no response for TIMEOUT cycles of WAIT
        tick();
        drive(32'h8000_0040, 64'h0, 3'd3, 1'b1, 1'b0);
        #1;
        chk("to_issue", req_valid, 1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            release_in();
            #1;
            if (k < TIMEOUT) begin
                if (timeout !== 1'b0 || stall !== 1'b1) begin
                    chk($sformatf("to_early_%0d", k), {timeout, stall}, 2'b01);
                end
            end else begin
                chk("to_set", timeout, 1);
                chk("to_stall", stall, 0);
            end
        end
        tick();
        #1;
        chk("to_sticky", timeout, 1);
        chk("to_idle_outv", out_valid, 0);
        drive(32'h8000_0048, 64'h0, 3'd3, 1'b1, 1'b0);
        #1;
        chk("to_idle_issue", req_valid, 1);
        tick();
        release_in();
        repeat (3) tick();
        chk("to_sticky2", timeout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
